// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic chain of NSTAGE pipeline registers (payload + valid)
// with per-stage stall/flush control and saturating stall/flush event counters.
// Stage 0 is fed from in_data/in_valid; stage NSTAGE-1 holds the oldest entry.
module pipe_stage_chain #(
  parameter int              NSTAGE = 4,
  parameter int              W      = 32,
  parameter logic [W-1:0]    BUBBLE = {W{1'b0}},
  parameter int              CNT_W  = 16
) (
  input  logic                clk,
  input  logic                R,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  input  logic [NSTAGE-1:0]   stall_mask,
  input  logic [NSTAGE-1:0]   flush_mask,
  output logic                in_ready,
  output logic [NSTAGE*W-1:0] out_data,
  output logic [NSTAGE-1:0]   out_valid,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  // A stall at stage k freezes k and everything younger (lower index).
  logic [NSTAGE-1:0] w_hold;
  // Stage receives a bubble because the stage above it is frozen.
  logic [NSTAGE-1:0] w_bubble_ins;
  // Stage is flushed while holding a real instruction.
  logic [NSTAGE-1:0] w_flush_hit;

  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      logic [W-1:0] r_data;
      logic         r_valid;
      logic [W-1:0] w_src_data;
      logic         w_src_valid;

      assign w_hold[gi]      = |stall_mask[NSTAGE-1:gi];
      assign w_flush_hit[gi] = flush_mask[gi] & r_valid;

      if (gi == 0) begin : g_head
        assign w_src_data       = in_data;
        assign w_src_valid      = in_valid;
        assign w_bubble_ins[gi] = 1'b0;
      end else begin : g_body
        assign w_src_data       = g_stage[gi-1].r_data;
        assign w_src_valid      = g_stage[gi-1].r_valid;
        assign w_bubble_ins[gi] = ~flush_mask[gi] & ~w_hold[gi] & w_hold[gi-1];
      end

      // Stage register: flush beats hold, hold beats bubble insertion, else advance.
      always_ff @(posedge clk or negedge R) begin
        if (!R) begin
          r_data  <= BUBBLE;
          r_valid <= 1'b0;
        end else if (flush_mask[gi] || w_bubble_ins[gi]) begin
          r_data  <= BUBBLE;
          r_valid <= 1'b0;
        end else if (!w_hold[gi]) begin
          r_data  <= w_src_data;
          r_valid <= w_src_valid;
        end
      end

      assign out_data[gi*W +: W] = r_data;
      assign out_valid[gi]       = r_valid;
    end
  endgenerate

  assign in_ready = ~w_hold[0];

  // Count cycles with any stall-induced bubble; saturate instead of wrapping.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_stall_cnt <= '0;
    end else if ((|w_bubble_ins) && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Count cycles squashing at least one valid entry; saturate instead of wrapping.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_flush_cnt <= '0;
    end else if ((|w_flush_hit) && !(&r_flush_cnt)) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of NSTAGE pipeline registers (e.g. IF_ID -> ID_EX -> EX_MEM -> MEM_WB) carrying a W-bit payload plus a valid bit per stage.
- Adds per-stage stall (hold with upstream back-pressure and downstream bubble insertion), per-stage flush (squash to NOP bubble) and saturating stall/flush event counters.
- Replaces hand-written per-stage registers with one generic block.

Parameters:
- NSTAGE, 4, number of register stages (>=2); stage 0 is fed by the inputs, stage NSTAGE-1 is the oldest.
- W, 32, payload width per stage.
- BUBBLE, {W{1'b0}}, payload loaded on flush, bubble insertion or reset (all-zero word = NOP).
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  reset, asynchronous, active-low.
- in_data  input  W  payload entering stage 0.
- in_valid  input  1  in_data is a real instruction.
- stall_mask  input  NSTAGE  bit i = stage i must hold this cycle.
- flush_mask  input  NSTAGE  bit i = stage i loads BUBBLE this cycle.
- in_ready  output  1  stage 0 accepts in_data this cycle.
- out_data  output  NSTAGE*W  stage i payload at [i*W +: W].
- out_valid  output  NSTAGE  valid bit per stage.
- stall_cnt  output  CNT_W  cycles in which at least one bubble was inserted by a stall.
- flush_cnt  output  CNT_W  cycles in which at least one valid entry was squashed by flush.

Behaviour:
- Reset (R=0, asynchronous): every stage payload = BUBBLE, out_valid = 0, stall_cnt = 0, flush_cnt = 0. Release is sampled at the next clk edge; no partial-cycle update.
- Derived hold: hold[i] = OR of stall_mask[j] for j>=i. A stall at stage k freezes stages 0..k.
- in_ready = !hold[0] (combinational).
- Per-stage update at posedge clk, in priority order:
  1. flush_mask[i]=1: load BUBBLE, valid <= 0. Flush beats hold; a flushed held stage keeps the bubble on following held cycles.
  2. hold[i]=1: keep payload and valid.
  3. i>0 and hold[i-1]=1: load BUBBLE, valid <= 0 (bubble insertion below the stall point).
  4. Otherwise: stage 0 loads {in_data,in_valid}; stage i>0 loads stage i-1.
- Latency: with no stall or flush, in_data appears at stage i after i+1 clock edges. The last stage's contents are dropped on each advance.
- Bubble event: rule 3 fires for any stage in a cycle -> stall_cnt +1, once per cycle.
- Flush event: rule 1 hits a stage whose valid=1 -> flush_cnt +1, once per cycle. Flushing already-invalid stages does not count.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Stall on stage NSTAGE-1: the whole chain freezes and no bubble is inserted.
- All stall_mask bits = 0 and flush_mask = all ones: chain becomes all bubbles, stage 0 does not load in_data.
- in_valid=0 with in_data nonzero is loaded as-is; validity is carried only by the valid bit.
- Inputs are sampled only at posedge clk. No combinational path from any input to out_data or out_valid.

Test Plan:
- Reset/flow: hold R=0 mid-run -> all out_valid=0, out_data=0, counters 0 immediately. Release, feed 0xE0810002, 0xE2433001, 0xE5954000 (valid) on consecutive cycles -> 0xE0810002 at stage 3 after 4 edges, 0xE5954000 at stage 3 after 6 edges.
- Stall insertion: NSTAGE=4, stages 0..3 = A,B,C,D valid; stall_mask=4'b0010 for 2 cycles -> stages 0,1 stay A,B; stage 2 = bubble (valid 0) both cycles; stage 3 = C then bubble; in_ready=0; stall_cnt=2.
- Flush vs hold: stall_mask=4'b0100, flush_mask=4'b0011 with stages 0,1 valid -> stages 0,1 become BUBBLE, stage 2 holds, stage 3 gets bubble; flush_cnt=1, stall_cnt=1. Same flush next cycle -> flush_cnt stays 1.
- Full stall at end: stall_mask=4'b1000 for 3 cycles -> all four stages unchanged, stall_cnt unchanged, in_ready=0.
- Saturation: CNT_W=4, assert stall_mask=4'b0001 for 20 cycles -> stall_cnt reaches 15 and holds at 15.
- Async reset mid-stall: assert R=0 between clock edges while stall_mask=4'b0010 -> outputs clear before the next edge. After release with no stall, the first in_data reaches stage 0 on the first edge.
